// File: rtl/tetris_pkg.sv
// Shared types and keycode decode helpers for the Tetris input stage.
package tetris_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        LEFT  = 3'd1,
        RIGHT = 3'd2,
        DROP  = 3'd3,
        ROT   = 3'd4,
        HARD  = 3'd5
    } action_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    function automatic action_t decode_key(input logic [7:0] key);
        case (key)
            KEY_A:     return LEFT;
            KEY_D:     return RIGHT;
            KEY_S:     return DROP;
            KEY_W:     return ROT;
            KEY_SPACE: return HARD;
            default:   return NONE;
        endcase
    endfunction

    // One-hot pulse vector: {hard, rotate, soft_drop, right, left}.
    function automatic logic [4:0] pulse_mask(input action_t act);
        case (act)
            LEFT:    return 5'b00001;
            RIGHT:   return 5'b00010;
            DROP:    return 5'b00100;
            ROT:     return 5'b01000;
            HARD:    return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic state_t entry_state(input action_t act);
        case (act)
            LEFT, RIGHT: return DELAY;
            DROP:        return REPEAT;
            ROT, HARD:   return HOLD;
            default:     return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Synchronises the frame_clk level into Clk and emits one-cycle rising-edge ticks.
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic frame_tick
);

    logic sync1_q;
    logic sync2_q;
    logic edge_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= frame_clk;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
        end
    end

    assign frame_tick = sync2_q & ~edge_q;

endmodule

// File: rtl/key_action_gen.sv
// Converts a held USB keycode into one-cycle game action pulses with DAS/ARR
// repeat for left/right, fixed-rate repeat for soft drop, single-shot otherwise.
module key_action_gen
    import tetris_pkg::*;
#(
    parameter int DAS_FRAMES  = 10,
    parameter int ARR_FRAMES  = 3,
    parameter int DROP_FRAMES = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic       move_left,
    output logic       move_right,
    output logic       soft_drop,
    output logic       rotate,
    output logic       hard_drop,
    output logic       held
);

    localparam logic [5:0] DAS_L  = 6'(DAS_FRAMES);
    localparam logic [5:0] ARR_L  = 6'(ARR_FRAMES);
    localparam logic [5:0] DROP_L = 6'(DROP_FRAMES);

    logic       frame_tick;
    logic [7:0] key_q;
    action_t    key_act;
    state_t     state_q;
    action_t    cur_act_q;
    logic [5:0] cnt_q;
    logic [5:0] cnt_inc;
    logic [5:0] period;
    logic [4:0] pulse_q;
    logic       held_q;

    frame_tick_sync u_frame_tick_sync (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .frame_tick (frame_tick)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_q <= 8'h00;
        end else begin
            key_q <= keycode;
        end
    end

    assign key_act = decode_key(key_q);
    assign cnt_inc = cnt_q + 6'd1;
    assign period  = (cur_act_q == DROP) ? DROP_L : ARR_L;

    // Release and new press take priority over a same-cycle frame tick.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            cur_act_q <= NONE;
            cnt_q     <= 6'd0;
            pulse_q   <= 5'b00000;
            held_q    <= 1'b0;
        end else begin
            pulse_q <= 5'b00000;
            if (key_act == NONE) begin
                state_q   <= IDLE;
                cur_act_q <= NONE;
                cnt_q     <= 6'd0;
                held_q    <= 1'b0;
            end else if (key_act != cur_act_q) begin
                pulse_q   <= pulse_mask(key_act);
                cur_act_q <= key_act;
                cnt_q     <= 6'd0;
                state_q   <= entry_state(key_act);
                held_q    <= 1'b1;
            end else if (frame_tick) begin
                case (state_q)
                    DELAY: begin
                        if (cnt_inc == DAS_L) begin
                            pulse_q <= pulse_mask(cur_act_q);
                            cnt_q   <= 6'd0;
                            state_q <= REPEAT;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    REPEAT: begin
                        if (cnt_inc == period) begin
                            pulse_q <= pulse_mask(cur_act_q);
                            cnt_q   <= 6'd0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign move_left  = pulse_q[0];
    assign move_right = pulse_q[1];
    assign soft_drop  = pulse_q[2];
    assign rotate     = pulse_q[3];
    assign hard_drop  = pulse_q[4];
    assign held       = held_q;

endmodule
